ram_control_5_ram: RTL and testbench



---
 rtl/ram_control_5_ram_pkg.sv | 21 ++
 rtl/ram_control_5_ram_if.sv | 33 +++
 rtl/ram_control_5_ram_addr_calc.sv | 32 +++
 rtl/ram_control_5_ram.sv | 118 +++++++++++
 tb/tb_ram_control_5_ram.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ram_control_5_ram_pkg.sv
// Shared constants and types for the dual-bank, five-RAM address generator.
// Optional feature macro: RAM_CONTROL_5_RAM_CLAMP_EN (saturate read addresses at DEPTH-1).
package ram_control_5_ram_pkg;

  localparam int ROW_W_DEF = 64;     // ROI row width in pixels
  localparam int DEPTH_DEF = 13504;  // ROI pixels held by each bank

  localparam int SLOTS   = 5;        // parallel RAMs per bank
  localparam int PTS     = 4;        // candidate points per bank
  localparam int COORD_W = 14;       // x / y coordinate width
  localparam int ADDR_W  = 15;       // RAM address width
  localparam int LIN_W   = 28;       // full-width linear address before reduction
  localparam int PIX_W   = 20;       // incoming pixel index width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } state_t;

endpackage

// File: rtl/ram_control_5_ram_if.sv
// Bus bundle between the matching pipeline and the address generator.
// Optional feature macro: RAM_CONTROL_5_RAM_CLAMP_EN (not used in this file).
interface ram_control_5_ram_if;
  import ram_control_5_ram_pkg::*;

  logic                      start;
  logic [PIX_W-1:0]          addr;
  logic [PTS*COORD_W-1:0]    new_xi;
  logic [PTS*COORD_W-1:0]    new_yi;
  logic [PTS*COORD_W-1:0]    new_xo;
  logic [PTS*COORD_W-1:0]    new_yo;
  logic [COORD_W-1:0]        xb_o;
  logic [COORD_W-1:0]        yb_o;
  logic [SLOTS*ADDR_W-1:0]   addr_a_5;
  logic [SLOTS*ADDR_W-1:0]   addr_b_5;
  logic                      w_en_a_5;
  logic                      w_en_b_5;
  logic                      data_input_rdy;
  logic                      roi_input_rdy;

  // Pipeline side: drives control, pixel index and points; receives addresses.
  modport master (
    output start, addr, new_xi, new_yi, new_xo, new_yo, xb_o, yb_o,
    input  addr_a_5, addr_b_5, w_en_a_5, w_en_b_5, data_input_rdy, roi_input_rdy
  );

  // Address generator side.
  modport slave (
    input  start, addr, new_xi, new_yi, new_xo, new_yo, xb_o, yb_o,
    output addr_a_5, addr_b_5, w_en_a_5, w_en_b_5, data_input_rdy, roi_input_rdy
  );

endinterface

// File: rtl/ram_control_5_ram_addr_calc.sv
// Linear address (y*ROW_W + x) for one point, reduced to the RAM address width.
// Optional feature macro: RAM_CONTROL_5_RAM_CLAMP_EN selects saturation at DEPTH-1;
// otherwise the address wraps to its low 15 bits.
module ram_addr_calc
  import ram_control_5_ram_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr
);

`ifdef RAM_CONTROL_5_RAM_CLAMP_EN
  logic [LIN_W-1:0] lin;

  // Full-width product so out-of-range points are detected, then saturate.
  always_comb begin
    lin = LIN_W'(y) * LIN_W'(ROW_W) + LIN_W'(x);
    if (lin >= LIN_W'(DEPTH)) addr = ADDR_W'(DEPTH - 1);
    else                      addr = lin[ADDR_W-1:0];
  end
`else
  // Wrap mode keeps only the low 15 bits; arithmetic mod 2^15 yields exactly
  // those bits of the full-width result, so the upper bits are never built.
  always_comb begin
    addr = ADDR_W'(y) * ADDR_W'(ROW_W) + ADDR_W'(x);
  end
`endif

endmodule

// File: rtl/ram_control_5_ram.sv
// Address generator for two banks of five pixel RAMs: streams the ROI into both
// banks (LOAD), then issues five read addresses per bank every cycle (READ).
// Optional feature macro: RAM_CONTROL_5_RAM_CLAMP_EN (saturate read addresses).
module ram_control_5_ram
  import ram_control_5_ram_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_control_5_ram_if.slave   bus
);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_a_w, addr_a_w_d;
  logic [ADDR_W-1:0]       addr_b_w, addr_b_w_d;
  logic [SLOTS*ADDR_W-1:0] addr_a_5_q, addr_a_5_d;
  logic [SLOTS*ADDR_W-1:0] addr_b_5_q, addr_b_5_d;
  logic                    w_en_q, w_en_d;
  logic                    data_input_rdy_q, data_input_rdy_d;
  logic                    roi_input_rdy, roi_input_rdy_d;

  logic [PTS*ADDR_W-1:0]   inner_addr;
  logic [PTS*ADDR_W-1:0]   outer_addr;
  logic [ADDR_W-1:0]       base_addr;
  logic                    addr_in_range;

  // One calculator per inner point (bank A) and per outer point (bank B).
  for (genvar gi = 0; gi < PTS; gi++) begin : g_pts
    ram_addr_calc #(.ROW_W(ROW_W), .DEPTH(DEPTH)) u_inner (
      .x    (bus.new_xi[gi*COORD_W +: COORD_W]),
      .y    (bus.new_yi[gi*COORD_W +: COORD_W]),
      .addr (inner_addr[gi*ADDR_W +: ADDR_W])
    );
    ram_addr_calc #(.ROW_W(ROW_W), .DEPTH(DEPTH)) u_outer (
      .x    (bus.new_xo[gi*COORD_W +: COORD_W]),
      .y    (bus.new_yo[gi*COORD_W +: COORD_W]),
      .addr (outer_addr[gi*ADDR_W +: ADDR_W])
    );
  end

  // The base point feeds slot 4 of both banks.
  ram_addr_calc #(.ROW_W(ROW_W), .DEPTH(DEPTH)) u_base (
    .x    (bus.xb_o),
    .y    (bus.yb_o),
    .addr (base_addr)
  );

  assign addr_in_range = (bus.addr < PIX_W'(DEPTH));

  // Next state and next registered outputs; outputs follow the next state so
  // they appear exactly one cycle after the inputs that caused them.
  always_comb begin
    state_d          = state_q;
    addr_a_w_d       = addr_a_w;
    addr_b_w_d       = addr_b_w;
    w_en_d           = 1'b0;
    data_input_rdy_d = 1'b0;
    roi_input_rdy_d  = 1'b0;
    addr_a_5_d       = {SLOTS{addr_a_w}};
    addr_b_5_d       = {SLOTS{addr_b_w}};

    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (bus.start && !addr_in_range) state_d = READ;
      READ:    state_d = READ;
      default: state_d = IDLE;
    endcase
    if (!bus.start) state_d = IDLE;

    if (state_d == LOAD) begin
      data_input_rdy_d = 1'b1;
      if (addr_in_range) begin
        addr_a_w_d = bus.addr[ADDR_W-1:0];
        addr_b_w_d = bus.addr[ADDR_W-1:0];
        w_en_d     = 1'b1;
      end
      addr_a_5_d = {SLOTS{addr_a_w_d}};
      addr_b_5_d = {SLOTS{addr_b_w_d}};
    end else if (state_d == READ) begin
      roi_input_rdy_d = 1'b1;
      addr_a_5_d      = {base_addr, inner_addr};
      addr_b_5_d      = {base_addr, outer_addr};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      addr_a_w         <= '0;
      addr_b_w         <= '0;
      addr_a_5_q       <= '0;
      addr_b_5_q       <= '0;
      w_en_q           <= 1'b0;
      data_input_rdy_q <= 1'b0;
      roi_input_rdy    <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_a_w         <= addr_a_w_d;
      addr_b_w         <= addr_b_w_d;
      addr_a_5_q       <= addr_a_5_d;
      addr_b_5_q       <= addr_b_5_d;
      w_en_q           <= w_en_d;
      data_input_rdy_q <= data_input_rdy_d;
      roi_input_rdy    <= roi_input_rdy_d;
    end
  end

  assign bus.addr_a_5       = addr_a_5_q;
  assign bus.addr_b_5       = addr_b_5_q;
  assign bus.w_en_a_5       = w_en_q;
  assign bus.w_en_b_5       = w_en_q;
  assign bus.data_input_rdy = data_input_rdy_q;
  assign bus.roi_input_rdy  = roi_input_rdy;

endmodule

// File: tb/tb_ram_control_5_ram.sv
// Directed bench for ram_control_5_ram: load, load->read boundary, read address
// sets (wrap or clamp depending on RAM_CONTROL_5_RAM_CLAMP_EN), stop and reset.
module tb_ram_control_5_ram;
  import ram_control_5_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  int xi[4], yi[4], xo[4], yo[4];

  ram_control_5_ram_if bus();

  ram_control_5_ram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_points();
    for (int k = 0; k < 4; k++) begin
      bus.new_xi[14*k +: 14] = 14'(xi[k]);
      bus.new_yi[14*k +: 14] = 14'(yi[k]);
      bus.new_xo[14*k +: 14] = 14'(xo[k]);
      bus.new_yo[14*k +: 14] = 14'(yo[k]);
    end
  endtask

  task automatic check_slots(input string tag, input int ea[5], input int eb[5]);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("%s_a%0d", tag, k), 80'(bus.addr_a_5[15*k +: 15]), 80'(ea[k]));
      check_val($sformatf("%s_b%0d", tag, k), 80'(bus.addr_b_5[15*k +: 15]), 80'(eb[k]));
    end
  endtask

  task automatic check_ctl(input string tag, input int wen, input int drdy, input int rrdy);
    check_val({tag, "_wen_a"}, 80'(bus.w_en_a_5), 80'(wen));
    check_val({tag, "_wen_b"}, 80'(bus.w_en_b_5), 80'(wen));
    check_val({tag, "_data_rdy"}, 80'(bus.data_input_rdy), 80'(drdy));
    check_val({tag, "_roi_rdy"}, 80'(bus.roi_input_rdy), 80'(rrdy));
  endtask

  initial begin
    int ea[5], eb[5];
    int clamp_on;
`ifdef RAM_CONTROL_5_RAM_CLAMP_EN
    clamp_on = 1;
`else
    clamp_on = 0;
`endif
    bus.start = 1'b0;
    bus.addr  = '0;
    bus.xb_o  = '0;
    bus.yb_o  = '0;
    for (int k = 0; k < 4; k++) begin
      xi[k] = 0; yi[k] = 0; xo[k] = 0; yo[k] = 0;
    end
    drive_points();

    // Reset state
    rst = 1'b1;
    step();
    check_ctl("reset", 0, 0, 0);
    check_val("reset_addr_a", 80'(bus.addr_a_5), 80'(0));
    check_val("reset_addr_b", 80'(bus.addr_b_5), 80'(0));
    rst = 1'b0;

    // Enter LOAD with first pixel
    bus.start = 1'b1;
    bus.addr  = 20'd0;
    step();
    check_ctl("load0", 1, 1, 0);
    ea = '{0, 0, 0, 0, 0}; eb = '{0, 0, 0, 0, 0};
    check_slots("load0", ea, eb);

    // Mid-ROI write address on all ten slots
    bus.addr = 20'd5000;
    step();
    check_ctl("load5000", 1, 1, 0);
    ea = '{5000, 5000, 5000, 5000, 5000}; eb = ea;
    check_slots("load5000", ea, eb);
    check_val("load5000_addr_a_w", 80'(dut.addr_a_w), 80'(5000));
    check_val("load5000_addr_b_w", 80'(dut.addr_b_w), 80'(5000));

    // Last in-range address
    bus.addr = 20'd13503;
    step();
    check_ctl("load13503", 1, 1, 0);
    ea = '{13503, 13503, 13503, 13503, 13503}; eb = ea;
    check_slots("load13503", ea, eb);

    // First out-of-range address: move to READ, no write
    bus.addr = 20'd13504;
    xi[0] = 10; yi[0] = 2;   xi[1] = 5;  yi[1] = 1;
    xi[2] = 0;  yi[2] = 211; xi[3] = 0;  yi[3] = 600;
    xo[0] = 1;  yo[0] = 1;   xo[1] = 63; yo[1] = 210;
    xo[2] = 7;  yo[2] = 100; xo[3] = 63; yo[3] = 0;
    bus.xb_o = 14'd63; bus.yb_o = 14'd210;
    drive_points();
    step();
    check_ctl("to_read", 0, 0, 1);
    check_val("to_read_roi_reg", 80'(dut.roi_input_rdy), 80'(1));

    // Read address set 1 (points held from previous cycle)
    step();
    check_ctl("read1", 0, 0, 1);
    ea = '{138, 69, clamp_on ? 13503 : 13504, clamp_on ? 13503 : 5632, 13503};
    eb = '{65, 13503, 6407, 63, 13503};
    check_slots("read1", ea, eb);

    // Read address set 2: new points every cycle, extreme base point
    xi[0] = 0; yi[0] = 0; xo[3] = 0; yo[3] = 1;
    drive_points();
    bus.xb_o = 14'd16383; bus.yb_o = 14'd16383;
    step();
    ea = '{0, 69, clamp_on ? 13503 : 13504, clamp_on ? 13503 : 5632, clamp_on ? 13503 : 16319};
    eb = '{65, 13503, 6407, 64, clamp_on ? 13503 : 16319};
    check_slots("read2", ea, eb);

    // Drop start mid-READ -> IDLE
    bus.start = 1'b0;
    step();
    check_ctl("stop", 0, 0, 0);
    check_val("stop_state", 80'(dut.state_q), 80'(IDLE));

    // Back into LOAD, then reset mid-LOAD
    bus.start = 1'b1;
    bus.addr  = 20'd100;
    step();
    check_ctl("reload", 1, 1, 0);
    ea = '{100, 100, 100, 100, 100}; eb = ea;
    check_slots("reload", ea, eb);
    rst = 1'b1;
    bus.addr = 20'd200;
    step();
    check_ctl("rst_load", 0, 0, 0);
    check_val("rst_load_addr_a", 80'(bus.addr_a_5), 80'(0));
    check_val("rst_load_addr_b", 80'(bus.addr_b_5), 80'(0));
    check_val("rst_load_state", 80'(dut.state_q), 80'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
